// File: rtl/present32_pkg.sv
// Shared definitions for the 32-bit PRESENT-style round chain: S-boxes,
// bit permutations, key rotation and the controller state encoding.
package present32_pkg;

    localparam int ROT_AMT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [31:0] sbox_layer(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y[4*i +: 4] = SBOX[x[4*i +: 4]];
        return y;
    endfunction

    function automatic logic [31:0] inv_sbox_layer(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y[4*i +: 4] = SBOX_INV[x[4*i +: 4]];
        return y;
    endfunction

    // Bit 31 is a fixed point; the rest move by multiplication mod 31.
    function automatic logic [31:0] perm(input logic [31:0] x);
        logic [31:0] y;
        y     = '0;
        y[31] = x[31];
        for (int i = 0; i < 31; i++) y[(8*i) % 31] = x[i];
        return y;
    endfunction

    function automatic logic [31:0] inv_perm(input logic [31:0] x);
        logic [31:0] y;
        y     = '0;
        y[31] = x[31];
        for (int j = 0; j < 31; j++) y[(4*j) % 31] = x[j];
        return y;
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] d;
        d = {x, x} << amt;
        return d[63:32];
    endfunction

endpackage

// File: rtl/present32_decrypt_inv_round.sv
// One combinational inverse round: undo the permutation, undo the S-box
// layer, then strip the round key.
module inv_round
    import present32_pkg::*;
(
    input  logic [31:0] state_i,
    input  logic [31:0] rkey_i,
    output logic [31:0] state_o
);

    assign state_o = inv_sbox_layer(inv_perm(state_i)) ^ rkey_i;

endmodule

// File: rtl/present32_decrypt.sv
// Iterative decryptor: one inverse round per clock, valid/ready on both
// sides, result held in ptext_o until the consumer takes it.
module present32_decrypt
    import present32_pkg::*;
#(
    parameter int DATAW   = 32,
    parameter int NROUNDS = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [DATAW-1:0] cipher_i,
    input  logic [DATAW-1:0] key_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DATAW-1:0] ptext_o
);

    localparam int CNTW = $clog2(NROUNDS) + 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NROUNDS - 1);

    fsm_e             fsm_q;
    logic [DATAW-1:0] state_q;
    logic [DATAW-1:0] key_q;
    logic [DATAW-1:0] ptext_q;
    logic [CNTW-1:0]  cnt_q;
    logic             ready_q;
    logic             valid_q;

    logic [4:0]       rot_amt_d;
    logic [DATAW-1:0] rkey_d;
    logic [DATAW-1:0] round_d;

    // The counter doubles as the round index, so rounds run last-to-first.
    assign rot_amt_d = 5'((ROT_AMT * int'(cnt_q)) % 32);
    assign rkey_d    = rotl32(key_q, rot_amt_d);

    inv_round u_inv_round (
        .state_i (state_q),
        .rkey_i  (rkey_d),
        .state_o (round_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            ptext_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        state_q <= cipher_i;
                        key_q   <= key_i;
                        cnt_q   <= LAST_CNT;
                        ready_q <= 1'b0;
                        fsm_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == '0) begin
                        ptext_q <= round_d;
                        valid_q <= 1'b1;
                        fsm_q   <= ST_DONE;
                    end else begin
                        state_q <= round_d;
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here means the next accept is a cycle later.
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        fsm_q   <= ST_IDLE;
                    end
                end
                default: begin
                    fsm_q   <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign ptext_o = ptext_q;

endmodule

// File: tb/tb_present32_decrypt.sv
// Scoreboard bench for present32_decrypt with one-round and eight-round instances.
`timescale 1ns/1ps
module tb_present32_decrypt;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        vi1 = 0, ro1, vo1, rd1 = 1;
    logic [31:0] c1 = '0, k1 = '0, p1;
    logic        vi8 = 0, ro8, vo8, rd8 = 1;
    logic [31:0] c8 = '0, k8 = '0, p8;

    present32_decrypt #(.DATAW(32), .NROUNDS(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vi1), .ready_o(ro1),
        .cipher_i(c1), .key_i(k1), .valid_o(vo1), .ready_i(rd1), .ptext_o(p1)
    );

    present32_decrypt #(.DATAW(32), .NROUNDS(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(vi8), .ready_o(ro8),
        .cipher_i(c8), .key_i(k8), .valid_o(vo8), .ready_i(rd8), .ptext_o(p8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent reference encryptor.
    localparam logic [3:0] TB_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    function automatic logic [31:0] ref_enc(input logic [31:0] pt, input logic [31:0] key, input int n);
        logic [31:0] x, s, y, k;
        int amt;
        x = pt;
        for (int r = 0; r < n; r++) begin
            amt = (3 * r) % 32;
            k = (amt == 0) ? key : ((key << amt) | (key >> (32 - amt)));
            x = x ^ k;
            for (int i = 0; i < 8; i++) s[4*i +: 4] = TB_SBOX[x[4*i +: 4]];
            y = '0;
            y[31] = s[31];
            for (int i = 0; i < 31; i++) y[(8*i) % 31] = s[i];
            x = y;
        end
        return x;
    endfunction

    typedef struct {
        logic [31:0] exp;
        int          acc;
    } sb_t;
    sb_t q1[$];
    sb_t q8[$];

    logic pv1 = 0, pv8 = 0;
    sb_t  e1, e8;
    always @(negedge clk) begin
        if (vo8 && !pv8) begin
            if (q8.size() == 0) check_eq("spurious_valid8", 32'd1, 32'd0);
            else begin
                e8 = q8.pop_front();
                $display("dut8 result ptext=%h exp=%h latency=%0d", p8, e8.exp, cyc - e8.acc);
                check_eq("ptext8", p8, e8.exp);
                check_eq("latency8", 32'(cyc - e8.acc), 32'd8);
            end
        end
        if (vo1 && !pv1) begin
            if (q1.size() == 0) check_eq("spurious_valid1", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                $display("dut1 result ptext=%h exp=%h latency=%0d", p1, e1.exp, cyc - e1.acc);
                check_eq("ptext1", p1, e1.exp);
                check_eq("latency1", 32'(cyc - e1.acc), 32'd1);
            end
        end
        pv8 <= vo8;
        pv1 <= vo1;
    end

    task automatic send8(input logic [31:0] pt, input logic [31:0] key);
        int t = 0;
        @(negedge clk);
        while (!ro8 && t < 100) begin @(negedge clk); t++; end
        if (!ro8) begin check_eq("ready_timeout8", 32'd0, 32'd1); return; end
        c8 = ref_enc(pt, key, 8); k8 = key; vi8 = 1'b1;
        q8.push_back('{exp: pt, acc: cyc + 1});
        @(negedge clk);
        vi8 = 1'b0;
    endtask

    task automatic send1(input logic [31:0] cipher, input logic [31:0] key, input logic [31:0] exp);
        int t = 0;
        @(negedge clk);
        while (!ro1 && t < 100) begin @(negedge clk); t++; end
        if (!ro1) begin check_eq("ready_timeout1", 32'd0, 32'd1); return; end
        c1 = cipher; k1 = key; vi1 = 1'b1;
        q1.push_back('{exp: exp, acc: cyc + 1});
        @(negedge clk);
        vi1 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q8.size() != 0) && t < 200) begin @(negedge clk); t++; end
        check_eq("drain_left", 32'(q1.size() + q8.size()), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pt, key, hold;
        int t, last, n_acc;

        repeat (2) @(negedge clk);
        check_eq("rst_ready8", {31'd0, ro8}, 32'd1);
        check_eq("rst_valid8", {31'd0, vo8}, 32'd0);
        check_eq("rst_ptext8", p8, 32'd0);
        check_eq("rst_ready1", {31'd0, ro1}, 32'd1);
        check_eq("rst_valid1", {31'd0, vo1}, 32'd0);
        check_eq("rst_ptext1", p1, 32'd0);
        rst_n = 1'b1;

        // One-round known answers, then a few random one-round blocks.
        send1(32'h0000_0000, 32'h0000_0000, 32'h5555_5555);
        send1(32'h0000_0000, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
        for (int i = 0; i < 6; i++) begin
            pt = $urandom; key = $urandom;
            send1(ref_enc(pt, key, 1), key, pt);
        end

        for (int i = 0; i < 1000; i++) begin
            pt = $urandom; key = $urandom;
            send8(pt, key);
        end
        drain();

        // Back-pressure in DONE, with noise on the input side.
        rd8 = 1'b0;
        send8(32'h1234_5678, 32'hCAFE_BABE);
        t = 0;
        while (!vo8 && t < 50) begin @(negedge clk); t++; end
        check_eq("bp_valid_seen", {31'd0, vo8}, 32'd1);
        hold = p8;
        for (int i = 0; i < 5; i++) begin
            c8 = $urandom; k8 = $urandom; vi8 = 1'b1;
            @(negedge clk);
            check_eq("bp_valid_hold", {31'd0, vo8}, 32'd1);
            check_eq("bp_ptext_hold", p8, hold);
            check_eq("bp_ready_low", {31'd0, ro8}, 32'd0);
        end
        vi8 = 1'b0;
        rd8 = 1'b1;
        @(negedge clk);
        check_eq("bp_release_valid", {31'd0, vo8}, 32'd0);
        check_eq("bp_release_ready", {31'd0, ro8}, 32'd1);

        // Asynchronous reset while the counter sits at 4.
        send8(32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, vo8}, 32'd0);
        check_eq("arst_ptext", p8, 32'd0);
        check_eq("arst_ready", {31'd0, ro8}, 32'd1);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check_eq("arst_no_valid", {31'd0, vo8}, 32'd0);
        end

        // valid_i held high with changing data: one accept every 10 cycles.
        last = -1;
        n_acc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            pt = $urandom; key = $urandom;
            c8 = ref_enc(pt, key, 8); k8 = key; vi8 = 1'b1;
            if (ro8) begin
                q8.push_back('{exp: pt, acc: cyc + 1});
                if (last >= 0) check_eq("accept_interval", 32'(cyc + 1 - last), 32'd10);
                last = cyc + 1;
                n_acc++;
            end
        end
        @(negedge clk);
        vi8 = 1'b0;
        check_eq("accept_count", 32'(n_acc), 32'd6);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/present32_decrypt.md
PRESENT32_DECRYPT -- requirements
Module: present32_decrypt

Interface
REQ-001 SHALL have parameter DATAW, default 32, meaning block and key width in bits (only 32 supported).
REQ-002 SHALL have parameter NROUNDS, default 1, meaning number of cipher rounds to invert (1..31).
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  cipher_i/key_i valid.
REQ-006 SHALL have port ready_o  output  1  block can accept a new input.
REQ-007 SHALL have port cipher_i  input  DATAW  ciphertext.
REQ-008 SHALL have port key_i  input  DATAW  cipher key.
REQ-009 SHALL have port valid_o  output  1  ptext_o holds a completed result.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port ptext_o  output  DATAW  recovered plaintext, registered.

Function
REQ-012 SHALL be the inverse of the team's encryption round chain: forward round r is c = P(S(x xor K_r)); rounds run r = 0..NROUNDS-1.
REQ-013 SHALL use round key K_r = key rotated left by 3*r bits (mod 32); K_0 = key.
REQ-014 SHALL use forward S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 and inverse S-box 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A, applied per nibble.
REQ-015 SHALL use forward P: bit i -> bit (8*i mod 31) for i<31, bit 31 fixed; inverse P: bit j -> bit (4*j mod 31) for j<31, bit 31 fixed.
REQ-016 SHALL compute one inverse round per cycle: x = Sinv(Pinv(state)) xor K_r, for r = NROUNDS-1 down to 0.
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 IDLE: ready_o=1, valid_o=0; on valid_i=1 SHALL latch cipher_i into state, latch key_i, load round counter with NROUNDS-1, go RUN.
REQ-019 RUN: ready_o=0; each cycle SHALL apply one inverse round; at counter 0 SHALL write the result to ptext_o and go DONE; otherwise decrement the counter.
REQ-020 DONE: valid_o=1, ptext_o stable; on ready_i=1 SHALL go IDLE; no new input SHALL be accepted in the same cycle.
REQ-021 Latency from the accept edge to valid_o=1 SHALL be exactly NROUNDS cycles; throughput SHALL be one block per NROUNDS+2 cycles with ready_i held at 1.
REQ-022 SHALL ignore cipher_i/key_i changes and valid_i outside IDLE; ready_i outside DONE SHALL have no effect.
REQ-023 ptext_o SHALL retain its last value in IDLE and RUN until overwritten at the end of RUN.

Reset
REQ-024 rst_ni=0 SHALL immediately force the state to IDLE and set ptext_o, valid_o, state register, key register and counter to 0; ready_o SHALL then read 1.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no result emitted.
REQ-026 After deassertion, the first accept SHALL take place no earlier than the first rising edge with rst_ni=1.

Structure
REQ-027 S-box and inverse S-box tables, permutation functions, FSM state enum and the key rotation amount (3) SHALL live in a shared package present32_pkg, shared with the encryptor.
REQ-028 The combinational inverse round SHALL be the sub-module inv_round (ports: state in, round key in, state out).
REQ-029 The round counter SHALL be $clog2(NROUNDS)+1 bits wide; key rotation SHALL be combinational from the latched key and counter.

Verification
REQ-030 NROUNDS=1, cipher 0x00000000, key 0x00000000 -> after 1 cycle valid_o=1, ptext_o=0x55555555.
REQ-031 NROUNDS=1, cipher 0x00000000, key 0xFFFFFFFF -> ptext_o=0xAAAAAAAA.
REQ-032 NROUNDS=8, 1000 random plaintext/key pairs encrypted by the reference model -> ptext_o equals the original plaintext in all cases, latency exactly 8.
REQ-033 Back-pressure: ready_i=0 for 5 cycles in DONE -> valid_o and ptext_o stay stable and ready_o=0; ready_i=1 -> IDLE on the next edge.
REQ-034 rst_ni pulsed low mid-RUN (NROUNDS=8, counter=4) -> valid_o=0, ptext_o=0, ready_o=1 asynchronously; no spurious valid_o afterwards.
REQ-035 valid_i held at 1 continuously with ready_i=1 -> one accept every NROUNDS+2 cycles, no accept while not in IDLE.
